// File: rtl/mem_arb_pkg.sv
// Shared types and default memory-map constants for the ROM/RAM access arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_D  = 1'b1
    } port_id_t;

    localparam int unsigned DEF_BIT_WIDTH = 32;
    localparam logic [31:0] DEF_ROM_BASE  = 32'h0040_0000;
    localparam logic [31:0] DEF_RAM_BASE  = 32'h1001_0000;
    localparam logic [31:0] DEF_ROM_BYTES = 32'h0000_1000;
    localparam logic [31:0] DEF_RAM_BYTES = 32'h0000_1000;

    function automatic logic is_word_aligned(input logic [1:0] lsbs);
        return lsbs == 2'b00;
    endfunction

endpackage

// File: rtl/mem_addr_decode.sv
// Combinational ROM/RAM window decode and access-legality check for one byte address.
module mem_addr_decode
    import mem_arb_pkg::*;
#(
    parameter int                   BIT_WIDTH = DEF_BIT_WIDTH,
    parameter logic [BIT_WIDTH-1:0] ROM_BASE  = BIT_WIDTH'(DEF_ROM_BASE),
    parameter logic [BIT_WIDTH-1:0] RAM_BASE  = BIT_WIDTH'(DEF_RAM_BASE),
    parameter logic [BIT_WIDTH-1:0] ROM_BYTES = BIT_WIDTH'(DEF_ROM_BYTES),
    parameter logic [BIT_WIDTH-1:0] RAM_BYTES = BIT_WIDTH'(DEF_RAM_BYTES)
) (
    input  logic [BIT_WIDTH-1:0] i_addr,
    input  logic                 i_is_store,
    input  logic                 i_is_fetch,
    output logic                 o_in_rom,
    output logic                 o_in_ram,
    output logic                 o_fault
);

    // One extra bit on every operand so base+size never wraps to a small limit.
    logic [BIT_WIDTH:0] w_addr_ext;
    logic [BIT_WIDTH:0] w_rom_lo;
    logic [BIT_WIDTH:0] w_rom_hi;
    logic [BIT_WIDTH:0] w_ram_lo;
    logic [BIT_WIDTH:0] w_ram_hi;

    assign w_addr_ext = {1'b0, i_addr};
    assign w_rom_lo   = {1'b0, ROM_BASE};
    assign w_rom_hi   = {1'b0, ROM_BASE} + {1'b0, ROM_BYTES};
    assign w_ram_lo   = {1'b0, RAM_BASE};
    assign w_ram_hi   = {1'b0, RAM_BASE} + {1'b0, RAM_BYTES};

    assign o_in_rom = (w_addr_ext >= w_rom_lo) && (w_addr_ext < w_rom_hi);
    assign o_in_ram = (w_addr_ext >= w_ram_lo) && (w_addr_ext < w_ram_hi);

    assign o_fault = !is_word_aligned(i_addr[1:0])
                   || !(o_in_rom || o_in_ram)
                   || (i_is_store && o_in_rom)
                   || (i_is_fetch && o_in_ram);

endmodule

// File: rtl/mem_access_arbiter.sv
// Shares the single ROM/RAM port between fetch and data requesters via an IDLE/ACCESS/RESP FSM.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default is fixed data-over-fetch.
module mem_access_arbiter
    import mem_arb_pkg::*;
#(
    parameter int                   BIT_WIDTH = DEF_BIT_WIDTH,
    parameter logic [BIT_WIDTH-1:0] ROM_BASE  = BIT_WIDTH'(DEF_ROM_BASE),
    parameter logic [BIT_WIDTH-1:0] RAM_BASE  = BIT_WIDTH'(DEF_RAM_BASE),
    parameter logic [BIT_WIDTH-1:0] ROM_BYTES = BIT_WIDTH'(DEF_ROM_BYTES),
    parameter logic [BIT_WIDTH-1:0] RAM_BYTES = BIT_WIDTH'(DEF_RAM_BYTES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_req,
    input  logic [BIT_WIDTH-1:0] if_addr,
    output logic                 if_gnt,
    output logic                 if_rvalid,
    output logic [BIT_WIDTH-1:0] if_rdata,
    output logic                 if_err,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [BIT_WIDTH-1:0] d_addr,
    input  logic [BIT_WIDTH-1:0] d_wdata,
    output logic                 d_gnt,
    output logic                 d_rvalid,
    output logic [BIT_WIDTH-1:0] d_rdata,
    output logic                 d_err,
    output logic [BIT_WIDTH-1:0] mem_addr,
    output logic [BIT_WIDTH-1:0] mem_wdata,
    output logic                 mem_we,
    input  logic [BIT_WIDTH-1:0] mem_rdata
);

    arb_state_t           r_state;
    port_id_t             r_port;
    logic                 r_we;
    logic                 r_fault;
    logic                 r_in_rom;
    logic                 r_in_ram;
    logic [BIT_WIDTH-1:0] r_mem_addr;
    logic [BIT_WIDTH-1:0] r_mem_wdata;
    logic [BIT_WIDTH-1:0] r_resp_data;
    logic                 r_if_gnt;
    logic                 r_d_gnt;
    logic                 r_if_rvalid;
    logic                 r_d_rvalid;
    logic                 r_if_err;
    logic                 r_d_err;
    logic [BIT_WIDTH-1:0] r_if_rdata;
    logic [BIT_WIDTH-1:0] r_d_rdata;

    logic                 w_any_req;
    logic                 w_pick_d;
    port_id_t             w_win_port;
    logic [BIT_WIDTH-1:0] w_win_addr;
    logic                 w_win_we;
    logic                 w_dec_in_rom;
    logic                 w_dec_in_ram;
    logic                 w_dec_fault;
    logic                 w_read_ok;

    assign w_any_req = if_req || d_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    port_id_t r_last_port;

    // On a tie the port that did not win last time goes first.
    assign w_pick_d = d_req && (!if_req || (r_last_port == PORT_IF));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_last_port <= PORT_IF;
        end else if ((r_state == ST_IDLE) && w_any_req) begin
            r_last_port <= w_win_port;
        end
    end
`else
    assign w_pick_d = d_req;
`endif

    assign w_win_port = w_pick_d ? PORT_D : PORT_IF;
    assign w_win_addr = w_pick_d ? d_addr : if_addr;
    assign w_win_we   = w_pick_d && d_we;

    mem_addr_decode #(
        .BIT_WIDTH (BIT_WIDTH),
        .ROM_BASE  (ROM_BASE),
        .RAM_BASE  (RAM_BASE),
        .ROM_BYTES (ROM_BYTES),
        .RAM_BYTES (RAM_BYTES)
    ) u_decode (
        .i_addr     (w_win_addr),
        .i_is_store (w_win_we),
        .i_is_fetch (!w_pick_d),
        .o_in_rom   (w_dec_in_rom),
        .o_in_ram   (w_dec_in_ram),
        .o_fault    (w_dec_fault)
    );

    assign w_read_ok = !r_fault && !r_we && (r_in_rom || r_in_ram);

    // NOTE: mem_we is qualified by rst so a store caught by reset never reaches the memory edge.
    assign mem_we = (r_state == ST_ACCESS) && r_we && r_in_ram && !r_fault && rst;

    // NOTE: all state updates use <= so every branch sees the pre-edge values of the other registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_port      <= PORT_IF;
            r_we        <= 1'b0;
            r_fault     <= 1'b0;
            r_in_rom    <= 1'b0;
            r_in_ram    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_resp_data <= '0;
            r_if_gnt    <= 1'b0;
            r_d_gnt     <= 1'b0;
            r_if_rvalid <= 1'b0;
            r_d_rvalid  <= 1'b0;
            r_if_err    <= 1'b0;
            r_d_err     <= 1'b0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
        end else begin
            r_if_gnt    <= 1'b0;
            r_d_gnt     <= 1'b0;
            r_if_rvalid <= 1'b0;
            r_d_rvalid  <= 1'b0;
            r_if_err    <= 1'b0;
            r_d_err     <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_port     <= w_win_port;
                        r_mem_addr <= w_win_addr;
                        r_we       <= w_win_we;
                        r_fault    <= w_dec_fault;
                        r_in_rom   <= w_dec_in_rom;
                        r_in_ram   <= w_dec_in_ram;
                        if (w_pick_d) begin
                            r_mem_wdata <= d_wdata;
                        end
                        r_d_gnt    <= w_pick_d;
                        r_if_gnt   <= !w_pick_d;
                        r_state    <= ST_ACCESS;
                    end
                end

                ST_ACCESS: begin
                    r_resp_data <= w_read_ok ? mem_rdata : '0;
                    r_state     <= ST_RESP;
                end

                ST_RESP: begin
                    if (r_port == PORT_D) begin
                        r_d_rvalid <= 1'b1;
                        r_d_err    <= r_fault;
                        r_d_rdata  <= r_resp_data;
                    end else begin
                        r_if_rvalid <= 1'b1;
                        r_if_err    <= r_fault;
                        r_if_rdata  <= r_resp_data;
                    end
                    r_state <= ST_IDLE;
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign if_gnt    = r_if_gnt;
    assign if_rvalid = r_if_rvalid;
    assign if_rdata  = r_if_rdata;
    assign if_err    = r_if_err;
    assign d_gnt     = r_d_gnt;
    assign d_rvalid  = r_d_rvalid;
    assign d_rdata   = r_d_rdata;
    assign d_err     = r_d_err;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Scoreboard bench for mem_access_arbiter with a behavioural ROM/RAM model on the memory port.
module tb_mem_access_arbiter;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        bit          err;
        bit          mwe;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    logic [31:0] ram    [0:1023];
    bit          ram_wr [0:1023];

    exp_t if_q[$];
    exp_t d_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   we_cnt   = 0;
    int   rv_cnt   = 0;
    int   if_gnt_cyc = 0;
    int   d_gnt_cyc  = 0;

    mem_access_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .if_err    (if_err),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ROM word i reads as A000_0000|i; unwritten RAM word i reads as 5000_0000|i.
    always_comb begin
        mem_rdata = 32'hBAD0_BAD0;
        if (mem_addr >= 32'h0040_0000 && mem_addr < 32'h0040_1000) begin
            mem_rdata = 32'hA000_0000 | {22'd0, mem_addr[11:2]};
        end else if (mem_addr >= 32'h1001_0000 && mem_addr < 32'h1001_1000) begin
            mem_rdata = ram_wr[mem_addr[11:2]] ? ram[mem_addr[11:2]]
                                               : (32'h5000_0000 | {22'd0, mem_addr[11:2]});
        end
    end

    always @(posedge clk) begin
        if (mem_we && mem_addr >= 32'h1001_0000 && mem_addr < 32'h1001_1000) begin
            ram[mem_addr[11:2]]    <= mem_wdata;
            ram_wr[mem_addr[11:2]] <= 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mem_we) we_cnt++;
        if (if_gnt && d_gnt) check("single_gnt", 32'(if_gnt) + 32'(d_gnt), 1);
        if (d_gnt) begin
            d_gnt_cyc = cyc;
            if (d_q.size() == 0) begin
                check("d_gnt_without_request", 32'(d_gnt), 0);
            end else begin
                check("d_mem_addr", mem_addr, d_q[$].addr);
                check("d_mem_we", 32'(mem_we), 32'(d_q[$].mwe));
            end
        end
        if (if_gnt) begin
            if_gnt_cyc = cyc;
            if (if_q.size() == 0) begin
                check("if_gnt_without_request", 32'(if_gnt), 0);
            end else begin
                check("if_mem_addr", mem_addr, if_q[$].addr);
                check("if_mem_we", 32'(mem_we), 0);
            end
        end
        if (d_rvalid) begin
            rv_cnt++;
            if (d_q.size() == 0) begin
                check("d_rvalid_without_request", 32'(d_rvalid), 0);
            end else begin
                e = d_q.pop_front();
                check("d_rdata", d_rdata, e.data);
                check("d_err", 32'(d_err), 32'(e.err));
                check("d_rvalid_latency", cyc - d_gnt_cyc, 2);
            end
        end
        if (if_rvalid) begin
            rv_cnt++;
            if (if_q.size() == 0) begin
                check("if_rvalid_without_request", 32'(if_rvalid), 0);
            end else begin
                e = if_q.pop_front();
                check("if_rdata", if_rdata, e.data);
                check("if_err", 32'(if_err), 32'(e.err));
                check("if_rvalid_latency", cyc - if_gnt_cyc, 2);
            end
        end
    end

    task automatic issue(input bit is_d, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_data,
                         input bit exp_err, input int exp_wait);
        exp_t e;
        int   waited;
        bit   got;
        e.addr = addr;
        e.data = exp_data;
        e.err  = exp_err;
        e.mwe  = we && !exp_err;
        waited = 0;
        got    = 1'b0;
        if (is_d) begin
            d_q.push_back(e);
            d_we    = we;
            d_addr  = addr;
            d_wdata = wdata;
            d_req   = 1'b1;
        end else begin
            if_q.push_back(e);
            if_addr = addr;
            if_req  = 1'b1;
        end
        while (!got && waited < 20) begin
            @(posedge clk);
            waited++;
            @(negedge clk);
            got = is_d ? d_gnt : if_gnt;
        end
        check(is_d ? "d_gnt_latency" : "if_gnt_latency", waited, exp_wait);
        if (is_d) d_req = 1'b0;
        else      if_req = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while ((if_q.size() != 0 || d_q.size() != 0) && n < 30);
        check("drain_outstanding", if_q.size() + d_q.size(), 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctrl"}, {25'd0, if_gnt, d_gnt, if_rvalid, d_rvalid, if_err, d_err, mem_we}, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_if_rdata"}, if_rdata, 0);
        check({tag, "_d_rdata"}, d_rdata, 0);
    endtask

    initial begin
        int we_before;
        int rv_before;
        rst = 1'b0; if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk); #1 rst = 1'b1;

        // Fetch from ROM word 1.
        issue(0, 0, 32'h0040_0004, 32'h0, 32'hA000_0001, 0, 1);
        drain();
        check("we_after_fetch", we_cnt, 0);

        // Store then load back through RAM.
        issue(1, 1, 32'h1001_0008, 32'hDEAD_BEEF, 32'h0, 0, 1);
        drain();
        check("we_after_store", we_cnt, 1);
        issue(1, 0, 32'h1001_0008, 32'h0, 32'hDEAD_BEEF, 0, 1);
        drain();

        // Faults and window edges.
        issue(1, 1, 32'h0040_0000, 32'h1111_2222, 32'h0, 1, 1);  drain();
        issue(1, 0, 32'h1001_0002, 32'h0, 32'h0, 1, 1);          drain();
        issue(1, 0, 32'h2000_0000, 32'h0, 32'h0, 1, 1);          drain();
        issue(0, 0, 32'h1001_0000, 32'h0, 32'h0, 1, 1);          drain();
        issue(1, 0, 32'h1001_0FFC, 32'h0, 32'h5000_03FF, 0, 1);  drain();
        issue(1, 0, 32'h1001_1000, 32'h0, 32'h0, 1, 1);          drain();
        issue(0, 0, 32'h0040_0FFC, 32'h0, 32'hA000_03FF, 0, 1);  drain();
        issue(0, 0, 32'h0040_1000, 32'h0, 32'h0, 1, 1);          drain();
        check("we_after_faults", we_cnt, 1);

        // Reset asserted during the ACCESS cycle of a store.
        we_before = we_cnt;
        rv_before = rv_cnt;
        d_q.push_back('{addr: 32'h1001_000C, data: 32'h0, err: 1'b0, mwe: 1'b0});
        d_we = 1'b1; d_addr = 32'h1001_000C; d_wdata = 32'h1234_5678; d_req = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; d_req = 1'b0; d_we = 1'b0;
        @(posedge clk); #1;
        d_q.delete();
        @(negedge clk);
        check_outputs_zero("drop");
        repeat (3) @(posedge clk);
        check("drop_we_count", we_cnt, we_before);
        check("drop_rvalid_count", rv_cnt, rv_before);
        #1 rst = 1'b1;

        // First tie after reset: data wins in both builds, fetch follows 3 cycles later.
        fork
            issue(1, 0, 32'h1001_0010, 32'h0, 32'h5000_0004, 0, 1);
            issue(0, 0, 32'h0040_0008, 32'h0, 32'hA000_0002, 0, 4);
        join
        drain();

        // The dropped store must not have reached RAM.
        issue(1, 0, 32'h1001_000C, 32'h0, 32'h5000_0003, 0, 1);
        drain();

        // Second tie, data granted last.
        fork
`ifdef MEM_ARB_ROUND_ROBIN_EN
            issue(1, 0, 32'h1001_0014, 32'h0, 32'h5000_0005, 0, 4);
            issue(0, 0, 32'h0040_000C, 32'h0, 32'hA000_0003, 0, 1);
`else
            issue(1, 0, 32'h1001_0014, 32'h0, 32'h5000_0005, 0, 1);
            issue(0, 0, 32'h0040_000C, 32'h0, 32'hA000_0003, 0, 4);
`endif
        join
        drain();

        check("we_total", we_cnt, 1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_access_arbiter.md
# mem_access_arbiter

Sequencer and arbiter for the unified ROM/RAM memory architecture of the multicycle MIPS core. It shares the single memory port between the instruction-fetch requester (read-only) and the data requester (load/store). Each access runs through a three-state FSM, and addresses are checked against the ROM and RAM windows before the memory is driven. It sits between the multicycle control/datapath and the memory architecture, and drives that block's address, write-data and write-enable inputs.

## Interface
- BIT_WIDTH, 32: data/address width.
- ROM_BASE, 32'h0040_0000: first byte of the ROM window.
- RAM_BASE, 32'h1001_0000: first byte of the RAM window.
- ROM_BYTES, 32'h0000_1000: ROM window size in bytes (multiple of 4).
- RAM_BYTES, 32'h0000_1000: RAM window size in bytes (multiple of 4).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; synchronous, active-low.
- if_req  input  1  fetch request; held until if_gnt.
- if_addr  input  BIT_WIDTH  fetch byte address.
- if_gnt  output  1  one-cycle pulse: fetch accepted.
- if_rvalid  output  1  one-cycle pulse: if_rdata/if_err valid.
- if_rdata  output  BIT_WIDTH  fetched word.
- if_err  output  1  fetch fault, qualified by if_rvalid.
- d_req  input  1  data request; held until d_gnt.
- d_we  input  1  1 = store, 0 = load.
- d_addr  input  BIT_WIDTH  data byte address.
- d_wdata  input  BIT_WIDTH  store data.
- d_gnt  output  1  one-cycle pulse: data request accepted.
- d_rvalid  output  1  one-cycle pulse: response valid (loads and stores).
- d_rdata  output  BIT_WIDTH  load data.
- d_err  output  1  data fault, qualified by d_rvalid.
- mem_addr  output  BIT_WIDTH  byte address to the memory architecture.
- mem_wdata  output  BIT_WIDTH  write data to memory.
- mem_we  output  1  memory write enable.
- mem_rdata  input  BIT_WIDTH  combinational read data from memory.

## Operation
- **FSM states:** IDLE, ACCESS, RESP.
- **IDLE:**
  - If any request is pending, pick a winner by priority.
  - Register the winner's address, write data, we and port id.
  - Run the address check on the winner.
  - Pulse that port's gnt and go to ACCESS.
  - With no request pending, stay in IDLE.
- **ACCESS:**
  - mem_addr = latched address for the whole cycle.
  - mem_we = 1 only when the access is a store with no fault.
  - Capture mem_rdata into the response register (forced to 0 on a fault or a store).
  - Go to RESP.
- **RESP:**
  - Pulse rvalid, with rdata and err, on the granted port only.
  - Go to IDLE.
- **Address check:** fault if any of the following holds.
  - addr[1:0] != 0.
  - Address inside neither [ROM_BASE, ROM_BASE+ROM_BYTES) nor [RAM_BASE, RAM_BASE+RAM_BYTES).
  - Store into the ROM window.
  - Fetch from the RAM window.
- **Window compare:** unsigned, on a BIT_WIDTH+1-bit sum so that base+size cannot wrap.
- **Default priority:** fixed, data over fetch. A data access stalls fetch in a multicycle core.
- **Simultaneous if_req and d_req:** exactly one gnt is issued; the loser stays pending.
- **Requests during ACCESS/RESP:** ignored. Requesters hold req until they see gnt.
- **Defaults when not driven by the FSM:**
  - mem_addr, mem_wdata hold their last latched values.
  - mem_we = 0.
  - rdata outputs hold the last response.
- **Reset (rst low at an edge):**
  - FSM returns to IDLE.
  - All gnt, rvalid and err outputs, mem_we, mem_addr, mem_wdata and both rdata registers go to 0.
  - A transaction in flight is dropped with no response.
  - No write occurs in the reset cycle.

## Timing
- Request sampled at edge N in IDLE:
  - gnt high in cycle N..N+1.
  - Memory driven in cycle N+1..N+2.
  - rvalid high in cycle N+2..N+3.
- Next grant possible at edge N+3, giving one access per 3 cycles.
- mem_we is high for exactly one cycle per good store; it is never high in IDLE or RESP.
- gnt and rvalid outputs are registered. mem_rdata is sampled only at the end of ACCESS.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN
  - **Defined:** round-robin priority. A 1-bit last-granted pointer, reset to "fetch", makes the port not granted last win a tie.
  - **Not defined:** fixed data-over-fetch priority; the pointer is not implemented.

## Structure
- Package mem_arb_pkg holds:
  - State enum (IDLE, ACCESS, RESP).
  - Port-id enum (PORT_IF, PORT_D).
  - Default ROM/RAM base and size constants.
- Sub-module mem_addr_decode:
  - Purely combinational.
  - Inputs: address, is_store, is_fetch.
  - Outputs: in_rom, in_ram, fault.
  - Instantiated once, on the winner's address.

## Test plan
- Fetch only, if_addr=32'h0040_0004 → if_gnt 1 cycle later, if_rvalid 2 cycles after gnt, if_rdata = ROM word 1, if_err=0, mem_we never 1.
- Store d_addr=32'h1001_0008, d_wdata=32'hDEAD_BEEF, then load same address → exactly one mem_we pulse, load returns 32'hDEAD_BEEF.
- if_req and d_req both high at the same edge:
  - Default build: d_gnt first, if_gnt 3 cycles later.
  - With MEM_ARB_ROUND_ROBIN_EN, two back-to-back ties: grants alternate D, IF.
- Faults, each → d_err=1, d_rdata=0, mem_we stays 0:
  - Store to 32'h0040_0000.
  - Load from 32'h1001_0002.
  - Load from 32'h2000_0000.
- rst low during ACCESS of a store → no mem_we pulse, no rvalid, all outputs 0; next request after release is served normally.
